// File: rtl/display_mux_driver.sv
// ============================================================================
// display_mux_driver
//
// Purpose:
//    Sits downstream of the frequency counter. Captures a tens/units BCD
//    result on a one-cycle load strobe, holds it in a pending buffer, and
//    promotes it to the active buffer only at a digit-slot boundary. One
//    7-segment bus is time-multiplexed across two digits. The digit select
//    toggles every REFRESH_DIV clocks. A half-updated display is therefore
//    never visible.
//
// Parameters:
//    REFRESH_DIV  clocks per digit slot (>= 2)
//    BLANK_LZ     1: blank the tens digit while the active tens value is 0
//
// Ports:
//    clk         in   1  system clock
//    reset       in   1  asynchronous, active-high reset
//    load        in   1  one-cycle strobe; capture ten_count/unit_count
//    ten_count   in   4  tens value (0-9 valid, 10-15 shown as a dash)
//    unit_count  in   4  units value (0-9 valid, 10-15 shown as a dash)
//    segments    out  7  active-high segments, bit0=a .. bit6=g, registered
//    digit       out  1  0 = units digit lit, 1 = tens digit lit, registered
// ============================================================================
module display_mux_driver #(
    parameter int REFRESH_DIV = 256,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] ten_count,
    input  logic [3:0] unit_count,
    output logic [6:0] segments,
    output logic       digit
);

    localparam int              CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(REFRESH_DIV - 1);

    logic [3:0]       r_pendT;
    logic [3:0]       r_pendU;
    logic             r_pendV;
    logic [3:0]       r_actT;
    logic [3:0]       r_actU;
    logic [CNT_W-1:0] r_refCnt;

    logic             w_boundary;
    logic [3:0]       w_actTNext;
    logic [3:0]       w_actUNext;
    logic             w_digitNext;
    logic [3:0]       w_shown;
    logic [6:0]       w_segNext;

    // BCD to active-high 7-segment pattern; anything above 9 shows a dash.
    function automatic logic [6:0] decode(input logic [3:0] value);
        logic [6:0] pattern;
        case (value)
            4'd0:    pattern = 7'h3F;
            4'd1:    pattern = 7'h06;
            4'd2:    pattern = 7'h5B;
            4'd3:    pattern = 7'h4F;
            4'd4:    pattern = 7'h66;
            4'd5:    pattern = 7'h6D;
            4'd6:    pattern = 7'h7D;
            4'd7:    pattern = 7'h07;
            4'd8:    pattern = 7'h7F;
            4'd9:    pattern = 7'h6F;
            default: pattern = 7'h40;
        endcase
        return pattern;
    endfunction

    // Next-state of the active buffer and digit select. A load that lands on
    // the boundary cycle bypasses the pending buffer so it is not delayed a
    // whole slot. The segment pattern is then decoded from these next-state
    // values, which keeps digit and segments changing on the same edge.
    always_comb begin
        w_boundary  = (r_refCnt == LAST);
        w_actTNext  = r_actT;
        w_actUNext  = r_actU;
        w_digitNext = digit;
        if (w_boundary) begin
            w_digitNext = ~digit;
            if (load) begin
                w_actTNext = ten_count;
                w_actUNext = unit_count;
            end else if (r_pendV) begin
                w_actTNext = r_pendT;
                w_actUNext = r_pendU;
            end
        end

        w_shown = w_digitNext ? w_actTNext : w_actUNext;
        if (BLANK_LZ && w_digitNext && (w_actTNext == 4'd0)) begin
            w_segNext = 7'h00;
        end else begin
            w_segNext = decode(w_shown);
        end
    end

    // Pending capture, refresh counter and the registered display outputs.
    // The pending valid flag is cleared on every boundary because whatever
    // was pending (or loaded this cycle) has just been promoted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pendT  <= 4'd0;
            r_pendU  <= 4'd0;
            r_pendV  <= 1'b0;
            r_actT   <= 4'd0;
            r_actU   <= 4'd0;
            r_refCnt <= '0;
            segments <= 7'h00;
            digit    <= 1'b0;
        end else begin
            if (load) begin
                r_pendT <= ten_count;
                r_pendU <= unit_count;
            end
            if (w_boundary) begin
                r_pendV  <= 1'b0;
                r_refCnt <= '0;
            end else begin
                if (load) begin
                    r_pendV <= 1'b1;
                end
                r_refCnt <= r_refCnt + CNT_W'(1);
            end
            r_actT   <= w_actTNext;
            r_actU   <= w_actUNext;
            digit    <= w_digitNext;
            segments <= w_segNext;
        end
    end

endmodule

// File: tb/tb_display_mux_driver.sv
// ============================================================================
// tb_display_mux_driver
//
// Two instances share all inputs: one with leading-zero blanking, one without.
// A behavioural model counts clock edges since reset release, tracks the
// latest load in the current slot, and derives the expected digit and
// segment pattern from slot arithmetic. It is checked against both DUTs on
// every falling edge. Directed literal checks pin the model and the DUTs at
// the interesting points; a randomized phase follows.
// ============================================================================
module tb_display_mux_driver;

    localparam int DIV = 4;

    logic       clk;
    logic       reset;
    logic       load;
    logic [3:0] tenCount;
    logic [3:0] unitCount;
    logic [6:0] segBlank;
    logic       digBlank;
    logic [6:0] segPlain;
    logic       digPlain;

    int errors;
    int checks;

    display_mux_driver #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b1)) dutBlank (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .ten_count  (tenCount),
        .unit_count (unitCount),
        .segments   (segBlank),
        .digit      (digBlank)
    );

    display_mux_driver #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b0)) dutPlain (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .ten_count  (tenCount),
        .unit_count (unitCount),
        .segments   (segPlain),
        .digit      (digPlain)
    );

    // Clock: period 10, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference segment patterns taken straight from the decode table.
    logic [6:0] segTbl [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

    // Behavioural model: n = clock edges since reset release; every DIV-th
    // edge is a slot boundary where the latest load (if any) becomes active.
    int n;
    bit pendValid;
    int pendT, pendU, actT, actU;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            n = 0; pendValid = 0; pendT = 0; pendU = 0; actT = 0; actU = 0;
        end else begin
            n = n + 1;
            if (load) begin
                pendT = int'(tenCount); pendU = int'(unitCount); pendValid = 1;
            end
            if (n % DIV == 0 && pendValid) begin
                actT = pendT; actU = pendU; pendValid = 0;
            end
        end
    end

    function automatic logic expDigit();
        return (n == 0) ? 1'b0 : logic'((n / DIV) % 2);
    endfunction

    function automatic logic [6:0] expSeg(input bit blank);
        if (n == 0) return 7'h00;
        if (expDigit()) begin
            if (blank && actT == 0) return 7'h00;
            return segTbl[actT];
        end
        return segTbl[actU];
    endfunction

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        checks = checks + 4;
        if (segBlank !== expSeg(1'b1)) begin
            errors = errors + 1;
            $display("[TB] FAIL cycle segBlank n=%0d: got %h required %h", n, segBlank, expSeg(1'b1));
        end
        if (segPlain !== expSeg(1'b0)) begin
            errors = errors + 1;
            $display("[TB] FAIL cycle segPlain n=%0d: got %h required %h", n, segPlain, expSeg(1'b0));
        end
        if (digBlank !== expDigit()) begin
            errors = errors + 1;
            $display("[TB] FAIL cycle digBlank n=%0d: got %b required %b", n, digBlank, expDigit());
        end
        if (digPlain !== expDigit()) begin
            errors = errors + 1;
            $display("[TB] FAIL cycle digPlain n=%0d: got %b required %b", n, digPlain, expDigit());
        end
    end

    // Drive inputs for exactly one rising edge; returns 2 time units after it.
    task automatic applyStimulus(input logic ld, input logic [3:0] t, input logic [3:0] u);
        load      = ld;
        tenCount  = t;
        unitCount = u;
        @(posedge clk);
        #2;
        load = 1'b0;
    endtask

    task automatic idleTo(input int target);
        int guard;
        guard = 0;
        while (n < target && guard < 1000) begin
            applyStimulus(1'b0, 4'd0, 4'd0);
            guard++;
        end
    endtask

    // Literal check of both DUTs and of the model itself.
    task automatic checkOutput(input string name, input logic [6:0] wantBlank,
                               input logic [6:0] wantPlain, input logic wantDig);
        checks = checks + 5;
        if (segBlank !== wantBlank) begin
            errors++; $display("[TB] FAIL %s segBlank: got %h required %h", name, segBlank, wantBlank);
        end
        if (segPlain !== wantPlain) begin
            errors++; $display("[TB] FAIL %s segPlain: got %h required %h", name, segPlain, wantPlain);
        end
        if (digBlank !== wantDig || digPlain !== wantDig) begin
            errors++; $display("[TB] FAIL %s digit: got %b/%b required %b", name, digBlank, digPlain, wantDig);
        end
        if (expSeg(1'b1) !== wantBlank) begin
            errors++; $display("[TB] FAIL %s model segBlank: got %h required %h", name, expSeg(1'b1), wantBlank);
        end
        if (expDigit() !== wantDig) begin
            errors++; $display("[TB] FAIL %s model digit: got %b required %b", name, expDigit(), wantDig);
        end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        reset     = 1'b1;
        load      = 1'b0;
        tenCount  = 4'd0;
        unitCount = 4'd0;

        // Reset holds outputs cleared before any clock edge.
        #3;
        checkOutput("reset", 7'h00, 7'h00, 1'b0);
        @(posedge clk);
        #2;
        reset = 1'b0;

        applyStimulus(1'b0, 4'd0, 4'd0);
        checkOutput("first edge", 7'h3F, 7'h3F, 1'b0);

        // Load mid-slot: nothing changes until the boundary at n=4.
        idleTo(2);
        applyStimulus(1'b1, 4'd4, 4'd2);
        checkOutput("load held", 7'h3F, 7'h3F, 1'b0);
        idleTo(4);
        checkOutput("tens 4", 7'h66, 7'h66, 1'b1);
        idleTo(8);
        checkOutput("units 2", 7'h5B, 7'h5B, 1'b0);

        // Out-of-range tens shows a dash.
        applyStimulus(1'b1, 4'd12, 4'd9);
        idleTo(12);
        checkOutput("dash", 7'h40, 7'h40, 1'b1);

        // Zero tens: blanked only on the BLANK_LZ instance.
        applyStimulus(1'b1, 4'd0, 4'd7);
        idleTo(16);
        checkOutput("units 7", 7'h07, 7'h07, 1'b0);
        idleTo(20);
        checkOutput("blank tens", 7'h00, 7'h3F, 1'b1);

        // Last load before a boundary wins.
        applyStimulus(1'b1, 4'd1, 4'd1);
        applyStimulus(1'b1, 4'd3, 4'd8);
        idleTo(24);
        checkOutput("last wins u", 7'h7F, 7'h7F, 1'b0);
        idleTo(28);
        checkOutput("last wins t", 7'h4F, 7'h4F, 1'b1);

        // Load on the boundary cycle is shown from that very edge.
        idleTo(31);
        applyStimulus(1'b1, 4'd5, 4'd5);
        checkOutput("boundary load", 7'h6D, 7'h6D, 1'b0);

        // Async reset mid-slot with a pending value: cleared without an edge.
        applyStimulus(1'b1, 4'd9, 4'd9);
        #1 reset = 1'b1;
        #1 checkOutput("async reset", 7'h00, 7'h00, 1'b0);
        @(posedge clk);
        #3 reset = 1'b0;
        applyStimulus(1'b0, 4'd0, 4'd0);
        checkOutput("post reset", 7'h3F, 7'h3F, 1'b0);
        idleTo(4);
        checkOutput("pending dropped t", 7'h00, 7'h3F, 1'b1);
        idleTo(8);
        checkOutput("pending dropped u", 7'h3F, 7'h3F, 1'b0);

        // Randomized phase, checked every cycle by the model comparison.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 3) begin
                reset = 1'b1;
                @(posedge clk);
                #2;
                reset = 1'b0;
            end else begin
                applyStimulus($urandom_range(0, 2) == 0,
                              4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            end
        end

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
